serial_pattern_tx: RTL
======================

// Module: serial_pattern_tx
// PURPOSE
//  Transmit side of the 1-bit serial line consumed by our pattern/chatter
//  detector: loads a parallel word and shifts it out one bit per clock on
//  'out', followed by an idle gap. Drives the detector's 'in' in system and
//  bench setups. Valid/ready load handshake plus a done pulse per frame.
// PARAMETERS
//  WIDTH       8   max frame length in bits (shift register width)
//  GAP_CYCLES  2   idle cycles driven after last bit before next frame (>=1)
//  IDLE_LEVEL  0   line level while idle, in gap and in reset (1 bit)
// PORTS
//  clk        in   1                   single clock, all state on posedge
//  rst        in   1                   synchronous, active-high reset
//  data_in    in   WIDTH               frame bits; sent data_in[len-1] first, down to [0]
//  len_in     in   $clog2(WIDTH+1)     bits to send; 0 or >WIDTH means WIDTH
//  valid_in   in   1                   load request
//  ready_out  out  1                   high when a load will be accepted
//  out        out  1                   serial line, registered
//  busy       out  1                   high while in SHIFT or GAP
//  done       out  1                   1-cycle pulse at end of each frame
// BEHAVIOUR
//  Clock/reset: one clock; reset synchronous, active-high. rst at posedge
//   forces: state=IDLE, out=IDLE_LEVEL, ready_out=1, busy=0, done=0,
//   bit/gap counters=0. Reset mid-frame aborts: no done pulse, rest unsent.
//  States: IDLE -> SHIFT -> GAP -> IDLE.
//  IDLE: ready_out=1, out=IDLE_LEVEL. Accept on posedge with
//   valid_in&&ready_out: latch data_in, effective len L, go SHIFT; out
//   becomes data_in[L-1] at that same edge (latency 0 cycles after accept).
//  SHIFT: each bit held exactly one cycle; bit counter counts L-1 down to 0;
//   after bit [0] has been held one cycle, go GAP, out=IDLE_LEVEL.
//   ready_out=0; valid_in/data_in/len_in ignored (changes have no effect).
//  GAP: out=IDLE_LEVEL for exactly GAP_CYCLES cycles, ready_out=0; then IDLE.
//  done: registered, high for exactly the first cycle back in IDLE (same
//   cycle ready_out re-asserts). If valid_in is high then, frame is
//   accepted at the next edge (back-to-back: gap of exactly GAP_CYCLES).
//  busy = (state != IDLE); ready_out = (state == IDLE) && !rst-effect.
//  Frame of L bits: accept edge to done-high edge = L+GAP_CYCLES cycles.
//  len_in width rule: compare as unsigned; L=WIDTH when len_in==0 or >WIDTH.
//  Bits above L-1 in data_in are don't-care and never appear on 'out'.
// STRUCTURE
//  Package serial_pattern_pkg: state enum tx_state_t {IDLE,SHIFT,GAP}
//   (2-bit), function eff_len(len,WIDTH), default parameter constants.
//  Sub-module: tx_shift_reg (WIDTH-bit parallel-load, MSB-aligned left
//   shift, load/shift enables); top holds FSM, bit and gap counters.
//  Load aligns frame so data_in[L-1] sits at MSB; 'out' taps MSB.
// TESTING
//  1 rst=1 for 2 cycles, valid_in=1 -> out=0, ready_out=1, busy=0, done=0.
//  2 WIDTH=8,GAP=2: data_in=8'hA7,len_in=0 -> out 1,0,1,0,0,1,1,1 then 0,0;
//    done high 10 cycles after accept edge, ready_out high same cycle.
//  3 data_in=8'h05,len_in=3 -> out 1,0,1 then 0,0; done after 5 cycles.
//  4 during frame of 8'hFF, pulse valid_in with 8'h00 -> ignored, out stays
//    1 for 8 cycles, ready_out=0 throughout SHIFT/GAP.
//  5 valid_in held high, 8'h81 then 8'h3C (len 8) -> exactly 2 gap cycles
//    between frames, one done pulse per frame, no bit lost or repeated.
//  6 rst=1 after 4 bits of 8'hF0 -> out=0 next edge, no done, ready_out=1;
//    following frame 8'h55 transmits correctly from bit 7.

Source files
------------

// File: rtl/serial_pattern_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_pkg
// Shared types and helpers for the serial pattern transmitter.
//   tx_state_t   : transmitter FSM state (IDLE -> SHIFT -> GAP -> IDLE)
//   eff_len()    : maps the requested frame length onto the number of bits
//                  actually sent (0 or anything above the width means "full")
//   DEFAULT_*    : default parameter values used by serial_pattern_tx
// -----------------------------------------------------------------------------
package serial_pattern_pkg;

  localparam int   DEFAULT_WIDTH      = 8;
  localparam int   DEFAULT_GAP_CYCLES = 2;
  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Length compared as unsigned; zero or oversize requests send a full word.
  function automatic int eff_len(input int len, input int width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/serial_pattern_tx_shift_reg.sv
// -----------------------------------------------------------------------------
// tx_shift_reg
// MSB-aligned parallel-load shift register feeding the serial line.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset, fills register with FILL
//   load_i  : parallel load of data_i (wins over shift_i)
//   shift_i : shift left by one, FILL enters at bit 0
//   data_i  : parallel word, first bit to send already at the MSB
//   msb_o   : current MSB, the registered serial output
// -----------------------------------------------------------------------------
module tx_shift_reg #(
  parameter int   WIDTH = 8,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic shift_in;
      if (gi == 0) begin : g_lsb
        assign shift_in = FILL;
      end else begin : g_upper
        assign shift_in = sr_q[gi-1];
      end
      assign sr_d[gi] = load_i ? data_i[gi] : (shift_i ? shift_in : sr_q[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= {WIDTH{FILL}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
// Loads a parallel word on a valid/ready handshake and shifts it out one bit
// per clock, MSB of the selected length first, followed by an idle gap.
// Ports:
//   clk       : single clock, all state on posedge
//   rst       : synchronous active-high reset (aborts any frame in flight)
//   data_in   : frame bits, data_in[L-1] is sent first, data_in[0] last
//   len_in    : bits to send; 0 or more than WIDTH sends WIDTH bits
//   valid_in  : load request
//   ready_out : high while a load will be accepted (IDLE)
//   out       : registered serial line
//   busy      : high while in SHIFT or GAP
//   done      : one-cycle pulse on the first cycle back in IDLE
// -----------------------------------------------------------------------------
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter int   GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL,
  parameter int   LEN_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             done_q, done_d;
  logic             load, shift;
  logic [CNT_W-1:0] len_m1;
  logic [WIDTH-1:0] aligned;

  // Align the frame so data_in[L-1] lands on the MSB. The vacated low bits
  // are filled with the idle level, so once the last frame bit has been
  // shifted past the MSB the line falls back to idle without a separate mux.
  always_comb begin
    int l;
    l       = eff_len(int'(len_in), WIDTH);
    len_m1  = CNT_W'(l - 1);
    aligned = (data_in << (WIDTH - l))
            | ({WIDTH{IDLE_LEVEL}} & ~({WIDTH{1'b1}} << (WIDTH - l)));
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          load      = 1'b1;
          bit_cnt_d = len_m1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Shift every cycle; after bit [0] the fill bit reaches the MSB.
        shift = 1'b1;
        if (bit_cnt_q == '0) begin
          gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
          state_d   = GAP;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

  tx_shift_reg #(
    .WIDTH (WIDTH),
    .FILL  (IDLE_LEVEL)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (aligned),
    .msb_o   (out)
  );

  assign ready_out = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
